// File: rtl/priority_encoder.sv
// priority_encoder: registered MSB-first priority encoder; define PRIORITY_ENCODER_ONEHOT_EN to add a onehot output
module priority_encoder #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  in,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    output logic [WIDTH-1:0]  onehot,
`endif
    output logic [CODE_W-1:0] code,
    output logic              valid
);
    logic [CODE_W-1:0] code_d;
    logic              valid_d;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [WIDTH-1:0]  onehot_d;
`endif
    // ascending scan so the highest set bit wins; an X/Z bit fails the test and is ignored
    always_comb begin
        code_d  = '0;
        valid_d = 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        onehot_d = '0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i] == 1'b1) begin
                code_d  = CODE_W'(i);
                valid_d = 1'b1;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
                onehot_d    = '0;
                onehot_d[i] = 1'b1;
`endif
            end
        end
    end
    // output registers: reset clears, enable captures, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            code  <= '0;
            valid <= 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
            onehot <= '0;
`endif
        end else if (en) begin
            code  <= code_d;
            valid <= valid_d;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
            onehot <= onehot_d;
`endif
        end
    end
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: randomized self-checking bench against a behavioural priority model
module tb_priority_encoder;
    localparam int WIDTH  = 8;
    localparam int CODE_W = 3;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [WIDTH-1:0]  in = '0;
    logic [CODE_W-1:0] code;
    logic              valid;
    int                tests = 0;
    int                fails = 0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [WIDTH-1:0]  onehot;
`endif

    priority_encoder #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in(in),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        .onehot(onehot),
`endif
        .code(code),
        .valid(valid)
    );

    always #5 clk = ~clk;

    // reference: search from the top down for the first bit that is exactly 1
    function automatic logic [CODE_W:0] model(input logic [WIDTH-1:0] v);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i] === 1'b1) return {1'b1, CODE_W'(i)};
        return '0;
    endfunction

    task automatic apply(input logic [WIDTH-1:0] v);
        in = v;
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_enc(input string name, input logic [CODE_W-1:0] c, input logic v);
        tests++;
        if (code !== c || valid !== v) begin
            fails++;
            $display("FAIL %s: got code=%b valid=%b, want code=%b valid=%b", name, code, valid, c, v);
        end
    endtask

    task automatic test_reset();
        in = '1;
        en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (code !== '0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL reset: got code=%b valid=%b, want 000/0", code, valid);
        end
    endtask

    task automatic test_single();
        apply(8'b1000_0000); expect_enc("single_b7", 3'b111, 1'b1);
        apply(8'b0000_0100); expect_enc("single_b2", 3'b010, 1'b1);
        apply(8'b0000_0001); expect_enc("single_b0", 3'b000, 1'b1);
    endtask

    task automatic test_priority();
        apply(8'b1000_0010); expect_enc("multi_b7b1", 3'b111, 1'b1);
        apply(8'b0001_0000); expect_enc("multi_b4", 3'b100, 1'b1);
        apply(8'b0111_1111); expect_enc("multi_low7", 3'b110, 1'b1);
    endtask

    task automatic test_unknown();
        apply(8'bxxxx_1xxx); expect_enc("unknown_x", 3'b011, 1'b1);
        apply(8'bzzzz_zz1z); expect_enc("unknown_z", 3'b001, 1'b1);
    endtask

    task automatic test_empty();
        apply(8'b1111_1111);
        apply(8'b0000_0000); expect_enc("empty", 3'b000, 1'b0);
    endtask

    task automatic test_enable();
        logic [CODE_W:0] exp;
        apply(8'b0010_0100); expect_enc("en_capture", 3'b101, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in = 8'(1 << (k + 6 > 7 ? 7 : k + 6)) | 8'($urandom);
            @(posedge clk);
            #1;
            expect_enc("en_hold", 3'b101, 1'b1);
        end
        in = 8'b0000_1000;
        #3;
        expect_enc("en_before_edge", 3'b101, 1'b1);
        en = 1'b1;
        @(posedge clk);
        #1;
        exp = model(8'b0000_1000);
        expect_enc("en_resume", exp[CODE_W-1:0], exp[CODE_W]);
        in = '1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_enc("rst_over_en", 3'b000, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        logic [CODE_W:0]  exp;
        for (int k = 0; k < 200; k++) begin
            v = 8'($urandom) >> $urandom_range(0, 7);
            apply(v);
            exp = model(v);
            expect_enc("random", exp[CODE_W-1:0], exp[CODE_W]);
        end
    endtask

    task automatic test_back_to_back();
        logic [CODE_W:0] q[$];
        logic [CODE_W:0] exp;
        logic [WIDTH-1:0] v;
        en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            v = ($urandom_range(0, 3) == 0) ? '0 : 8'($urandom);
            in = v;
            q.push_back(model(v));
            @(posedge clk);
            #1;
            exp = q.pop_front();
            expect_enc("back_to_back", exp[CODE_W-1:0], exp[CODE_W]);
        end
    endtask

`ifdef PRIORITY_ENCODER_ONEHOT_EN
    task automatic test_onehot();
        apply(8'b0110_0000);
        expect_enc("onehot_code", 3'b110, 1'b1);
        tests++;
        if (onehot !== 8'b0100_0000) begin
            fails++;
            $display("FAIL onehot: got %b, want 01000000", onehot);
        end
        apply(8'b0000_0000);
        tests++;
        if (onehot !== 8'b0000_0000) begin
            fails++;
            $display("FAIL onehot_empty: got %b, want 00000000", onehot);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_unknown();
        test_empty();
        test_enable();
        test_random();
        test_back_to_back();
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        test_onehot();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8; number of request bits; legal range 2..64.
REQ-002 SHALL have parameter CODE_W, default 3; code width, equal to ceil(log2(WIDTH)).
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit; capture enable; when low, registered outputs hold their value.
REQ-006 SHALL have port in, input, WIDTH bits; request vector.
REQ-007 SHALL have port code, output, CODE_W bits; index of the highest-priority set bit of in.
REQ-008 SHALL have port valid, output, 1 bit; high when the captured in had at least one bit set.

Function
REQ-009 SHALL use MSB-first priority: code = index of the most significant bit of in that equals 1; all lower bits are ignored.
REQ-010 SHALL treat any in bit that is X or Z in simulation as not set, so only bits strictly equal to 1 compete.
REQ-011 SHALL, when no bit of in is set, drive code = 0 and valid = 0.
REQ-012 SHALL register code and valid with exactly 1 clk cycle of latency from in sampled with en = 1.
REQ-013 SHALL, when en = 0 and rst = 0, leave code and valid unchanged.
REQ-014 SHALL compute the encode as pure combinational logic feeding the output registers, with no other internal state.
REQ-015 SHALL produce a code that is always in the range 0..WIDTH-1 and never X when rst has been applied.

Reset
REQ-016 SHALL, on a rising clk with rst = 1, set code = 0 and valid = 0; rst takes priority over en.
REQ-017 SHALL, after rst is released, make the first valid result available one cycle after the first enabled sample.

Configuration
REQ-018 SHALL, with macro PRIORITY_ENCODER_ONEHOT_EN defined, add an output port onehot, WIDTH bits, registered alongside code, with only the winning bit set (all zeros when valid = 0, reset value 0).
REQ-019 SHALL, without PRIORITY_ENCODER_ONEHOT_EN, omit the onehot port and its logic entirely; code and valid behaviour are identical in both builds.

Verification
REQ-020 SHALL check single-bit inputs: in = 10000000 -> code = 111, valid = 1; in = 00000100 -> code = 010; in = 00000001 -> code = 000, valid = 1.
REQ-021 SHALL check multi-bit priority: in = 10000010 -> code = 111; in = 00010000 -> code = 100.
REQ-022 SHALL check unknown bits: in = xxxx1xxx -> code = 011; in = zzzzzz1z -> code = 001; valid = 1 in both cases.
REQ-023 SHALL check the empty case: in = 00000000 -> code = 000, valid = 0.
REQ-024 SHALL check reset and enable: assert rst with in = 11111111 -> code = 0 and valid = 0; then en = 0 with changing in -> outputs hold; then en = 1 -> result appears after 1 cycle.
REQ-025 SHALL check, with PRIORITY_ENCODER_ONEHOT_EN defined, that in = 01100000 -> onehot = 01000000 and code = 110.
